// File: rtl/hls_macc_n_obf_pkg.sv
// macc_obf_pkg: shared FSM states, unlock constant and key-pattern helper for the locked MACC
package macc_obf_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_MUL,
      S_SUM,
      S_DUMMY,
      S_DONE
   } state_e;

   localparam int MAX_W = 256;
   localparam logic [7:0] KEY_CORRECT = 8'hA5;

   // replicates the low key_w bits of key across width bits; caller truncates to its WIDTH
   function automatic logic [MAX_W-1:0] key_pattern(input logic [MAX_W-1:0] key, input int key_w, input int width);
      logic [MAX_W-1:0] p;
      p = '0;
      for (int i = 0; i < width; i += key_w) p = p | (key << i);
      return p;
   endfunction

endpackage

// File: rtl/hls_macc_n_obf_if.sv
// hls_macc_n_obf_if: ap_ctrl_hs handshake, operand and result bundle of the locked MACC
interface hls_macc_n_obf_if #(
   parameter int WIDTH = 32,
   parameter int LANES = 4,
   parameter int KEY_W = 8
);
   logic                   ap_start;
   logic                   ap_done;
   logic                   ap_ready;
   logic                   ap_idle;
   logic [LANES*WIDTH-1:0] in_a;
   logic [LANES*WIDTH-1:0] in_b;
   logic                   mode;
   logic                   acc_clr;
   logic [KEY_W-1:0]       key;
   logic [WIDTH-1:0]       out_sum;
   logic                   out_sum_ap_vld;
   logic [WIDTH-1:0]       out_acc;

   modport master (
      output ap_start, in_a, in_b, mode, acc_clr, key,
      input  ap_done, ap_ready, ap_idle, out_sum, out_sum_ap_vld, out_acc
   );

   modport slave (
      input  ap_start, in_a, in_b, mode, acc_clr, key,
      output ap_done, ap_ready, ap_idle, out_sum, out_sum_ap_vld, out_acc
   );
endinterface

// File: rtl/hls_macc_n_obf_adder_tree.sv
// macc_adder_tree: combinational mod-2^WIDTH reduction of the packed lane products
module macc_adder_tree #(
   parameter int WIDTH = 32,
   parameter int LANES = 4
) (
   input  logic [LANES*WIDTH-1:0] prod,
   output logic [WIDTH-1:0]       sum
);

   // sum all lanes, carries beyond WIDTH dropped
   always_comb begin
      sum = '0;
      for (int i = 0; i < LANES; i++) sum = sum + prod[i*WIDTH +: WIDTH];
   end

endmodule

// File: rtl/hls_macc_n_obf.sv
// hls_macc_n_obf: key-locked multi-lane dot product / accumulator with ap_ctrl_hs handshake
module hls_macc_n_obf
   import macc_obf_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int LANES = 4,
   parameter int KEY_W = 8
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   hls_macc_n_obf_if.slave   bus
);

   localparam logic [KEY_W-1:0] KEY_OK = KEY_W'(KEY_CORRECT);

   state_e                 state_q, state_d;
   logic [LANES*WIDTH-1:0] a_q, a_d, b_q, b_d, prod_q, prod_d;
   logic                   mode_q, mode_d, clr_q, clr_d, start;
   logic [KEY_W-1:0]       key_q, key_d;
   logic [WIDTH-1:0]       sum_q, sum_d, acc_q, acc_d, out_q, out_d, tree_sum, pat;

   macc_adder_tree #(.WIDTH(WIDTH), .LANES(LANES)) u_tree (
      .prod (prod_q),
      .sum  (tree_sum)
   );

   // wrong keys divert through DUMMY; DONE and illegal encodings fall back to IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.ap_start) state_d = S_LOAD;
         S_LOAD:  state_d = S_MUL;
         S_MUL:   state_d = S_SUM;
         S_SUM:   state_d = (key_q == KEY_OK) ? S_DONE : S_DUMMY;
         S_DUMMY: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // datapath: capture at start, multiply in LOAD, reduce/accumulate in MUL, corrupt in DUMMY
   always_comb begin
      start  = (state_q == S_IDLE) && bus.ap_start;
      a_d    = start ? bus.in_a : a_q;
      b_d    = start ? bus.in_b : b_q;
      mode_d = start ? bus.mode : mode_q;
      clr_d  = start ? bus.acc_clr : clr_q;
      key_d  = start ? bus.key : key_q;
      pat    = WIDTH'(key_pattern(MAX_W'(key_q), KEY_W, WIDTH));
      prod_d = prod_q;
      if (state_q == S_LOAD)
         for (int i = 0; i < LANES; i++) prod_d[i*WIDTH +: WIDTH] = a_q[i*WIDTH +: WIDTH] * b_q[i*WIDTH +: WIDTH];
      sum_d = (state_q == S_MUL) ? tree_sum : (state_q == S_DUMMY) ? sum_q ^ pat : sum_q;
      acc_d = !mode_q ? acc_q :
              (state_q == S_MUL) ? (clr_q ? '0 : acc_q) + tree_sum :
              (state_q == S_DUMMY) ? acc_q ^ pat : acc_q;
      out_d = (state_d == S_DONE) ? (mode_q ? acc_d : sum_d) : out_q;
   end

   // state and data registers, asynchronously cleared
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         prod_q  <= '0;
         mode_q  <= 1'b0;
         clr_q   <= 1'b0;
         key_q   <= '0;
         sum_q   <= '0;
         acc_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         prod_q  <= prod_d;
         mode_q  <= mode_d;
         clr_q   <= clr_d;
         key_q   <= key_d;
         sum_q   <= sum_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
      end
   end

   assign bus.ap_done        = (state_q == S_DONE);
   assign bus.ap_ready       = (state_q == S_DONE);
   assign bus.out_sum_ap_vld = (state_q == S_DONE);
   assign bus.ap_idle        = (state_q == S_IDLE) && !bus.ap_start;
   assign bus.out_sum        = out_q;
   assign bus.out_acc        = acc_q;

endmodule

// File: tb/tb_hls_macc_n_obf.sv
// tb_hls_macc_n_obf: directed and randomized checks of the locked MACC against a dot-product model
module tb_hls_macc_n_obf;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   logic [31:0] acc_m = '0;

   localparam logic [127:0] OPA = {32'd4, 32'd3, 32'd2, 32'd1};
   localparam logic [127:0] OPB = {32'd8, 32'd7, 32'd6, 32'd5};

   always #5 clk = ~clk;

   hls_macc_n_obf_if #(.WIDTH(32), .LANES(4), .KEY_W(8)) bus ();

   hls_macc_n_obf #(.WIDTH(32), .LANES(4), .KEY_W(8)) dut (
      .ap_clk   (clk),
      .ap_rst_n (rst_n),
      .bus      (bus.slave)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] dot(input logic [127:0] a, input logic [127:0] b);
      logic [31:0] s;
      s = '0;
      for (int i = 0; i < 4; i++) s = s + a[i*32 +: 32] * b[i*32 +: 32];
      return s;
   endfunction

   task automatic run(input logic [127:0] a, input logic [127:0] b, input logic m, input logic c,
                      input logic [7:0] k, input logic [7:0] km, input bit pulse, input string tag);
      logic [31:0] d, exp_sum, pat;
      int lat;
      bit wrong;
      d = dot(a, b);
      wrong = (k != 8'hA5);
      pat = {4{k}};
      if (m) begin
         acc_m = (c ? 32'd0 : acc_m) + d;
         if (wrong) acc_m = acc_m ^ pat;
         exp_sum = acc_m;
      end else exp_sum = wrong ? d ^ pat : d;
      @(negedge clk);
      bus.in_a = a;
      bus.in_b = b;
      bus.mode = m;
      bus.acc_clr = c;
      bus.key = k;
      bus.ap_start = 1'b1;
      lat = 0;
      for (int i = 1; i <= 12 && lat == 0; i++) begin
         @(posedge clk);
         #1;
         if (i == 1) begin
            bus.ap_start = 1'b0;
            bus.key = km;
            bus.in_a = {$urandom, $urandom, $urandom, $urandom};
            bus.in_b = {$urandom, $urandom, $urandom, $urandom};
            bus.mode = ~m;
            bus.acc_clr = ~c;
         end
         if (pulse) bus.ap_start = (i == 2);
         if (bus.ap_done) lat = i;
      end
      chk({tag, "_lat"}, lat, wrong ? 5 : 4);
      chk({tag, "_sum"}, bus.out_sum, exp_sum);
      chk({tag, "_acc"}, bus.out_acc, acc_m);
      chk({tag, "_rdy"}, {bus.ap_ready, bus.out_sum_ap_vld}, 2'b11);
      @(posedge clk);
      #1;
      chk({tag, "_post"}, {bus.ap_done, bus.ap_idle, bus.out_sum}, {1'b0, 1'b1, exp_sum});
      if (pulse) begin
         lat = 0;
         repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.ap_done) lat++;
         end
         chk({tag, "_nostart"}, lat, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int prev, nd, idle_seen;
      bus.ap_start = 1'b1;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.mode = 1'b0;
      bus.acc_clr = 1'b0;
      bus.key = 8'hA5;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_idle_start", bus.ap_idle, 1'b0);
      bus.ap_start = 1'b0;
      #1;
      chk("rst_outs", {bus.out_sum, bus.out_acc, bus.ap_done, bus.ap_ready, bus.out_sum_ap_vld, bus.ap_idle},
          {32'd0, 32'd0, 4'b0001});
      @(negedge clk);
      rst_n = 1'b1;

      run(OPA, OPB, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, "dot");
      run({96'd0, 32'hFFFFFFFF}, {96'd0, 32'd2}, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, "wrap1");
      run({4{32'h80000000}}, {4{32'd2}}, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, "wrap2");
      run(OPA, OPB, 1'b1, 1'b0, 8'hA5, 8'hA5, 1'b0, "acc1");
      chk("acc1_val", acc_m, 32'd70);
      run(OPA, OPB, 1'b1, 1'b0, 8'hA5, 8'hA5, 1'b0, "acc2");
      chk("acc2_val", acc_m, 32'd140);
      run(OPA, OPB, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, "mode0_mid");
      run(OPA, OPB, 1'b1, 1'b1, 8'hA5, 8'hA5, 1'b0, "accclr");
      run(OPA, OPB, 1'b0, 1'b0, 8'hA4, 8'hA5, 1'b0, "wrongkey");
      chk("wrongkey_const", dot(OPA, OPB) ^ {4{8'hA4}}, 32'hA4A4A4E2);
      run(OPA, OPB, 1'b1, 1'b0, 8'h3C, 8'hA5, 1'b0, "wrongkey_acc");
      run(OPA, OPB, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b1, "pulse");

      // start held high: a new run every 5 cycles, never idle
      @(negedge clk);
      bus.in_a = OPA;
      bus.in_b = OPB;
      bus.mode = 1'b0;
      bus.key = 8'hA5;
      bus.ap_start = 1'b1;
      prev = 0;
      nd = 0;
      idle_seen = 0;
      for (int i = 1; i <= 27; i++) begin
         @(posedge clk);
         #1;
         if (bus.ap_idle) idle_seen++;
         if (bus.ap_done) begin
            if (prev != 0) chk("hs_period", i - prev, 5);
            prev = i;
            nd++;
         end
      end
      chk("hs_count", nd, 5);
      chk("hs_no_idle", idle_seen, 0);
      @(negedge clk);
      bus.ap_start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("hs_end", {bus.ap_idle, bus.out_sum}, {1'b1, 32'd70});

      // reset while in SUM
      @(negedge clk);
      bus.in_a = OPA;
      bus.in_b = OPB;
      bus.mode = 1'b1;
      bus.acc_clr = 1'b0;
      bus.ap_start = 1'b1;
      @(posedge clk);
      #1;
      bus.ap_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      acc_m = '0;
      #1;
      chk("midrst_outs", {bus.out_sum, bus.out_acc, bus.ap_done, bus.ap_ready, bus.out_sum_ap_vld, bus.ap_idle},
          {32'd0, 32'd0, 4'b0001});
      nd = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (bus.ap_done) nd++;
      end
      chk("midrst_nodone", nd, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run(OPA, OPB, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, "after_rst");
      run(OPA, OPB, 1'b1, 1'b0, 8'hA5, 8'hA5, 1'b0, "after_rst_acc");

      for (int r = 0; r < 24; r++) begin
         logic [7:0] k;
         k = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hA5;
         run({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
             1'($urandom), 1'($urandom_range(0, 4) == 0), k, 8'($urandom), 1'($urandom), "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
